cla_stream_accumulator: RTL

//   Sequential front end for the 32-bit carry-lookahead adder (CLA_32bit).

---
 rtl/cla_stream_accumulator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cla_stream_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cla_stream_accumulator                                         |
// | Brief   : Streams a burst of 32-bit words through a carry-lookahead     |
// |           adder into a running total and counts adder carry-outs.       |
// | Options : CLA_ACC_SAT_EN - saturate the total on carry-out              |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module cla_stream_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             busy
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_accum = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_carry_cnt;
  logic             w_beat;

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;
  logic [7:0]  w_grp_g;
  logic [7:0]  w_grp_p;
  logic [8:0]  w_gc;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [31:0] w_acc_next;

  // Adder operands: running total plus incoming word, carry-in tied to zero.
  assign w_g = r_acc & in_data;
  assign w_p = r_acc ^ in_data;

  for (genvar i = 0; i < 8; i++) begin : g_grp
    assign w_grp_p[i] = &w_p[4*i +: 4];
    assign w_grp_g[i] = w_g[4*i+3]
                      | (w_p[4*i+3] & w_g[4*i+2])
                      | (w_p[4*i+3] & w_p[4*i+2] & w_g[4*i+1])
                      | (w_p[4*i+3] & w_p[4*i+2] & w_p[4*i+1] & w_g[4*i]);
  end

  // Group carries chain across nibbles; bit carries look ahead inside each nibble.
  always_comb begin
    w_gc = '0;
    w_c  = '0;
    for (int i = 0; i < 8; i++) begin
      w_c[4*i]   = w_gc[i];
      w_c[4*i+1] = w_g[4*i] | (w_p[4*i] & w_gc[i]);
      w_c[4*i+2] = w_g[4*i+1] | (w_p[4*i+1] & w_g[4*i])
                 | (w_p[4*i+1] & w_p[4*i] & w_gc[i]);
      w_c[4*i+3] = w_g[4*i+2] | (w_p[4*i+2] & w_g[4*i+1])
                 | (w_p[4*i+2] & w_p[4*i+1] & w_g[4*i])
                 | (w_p[4*i+2] & w_p[4*i+1] & w_p[4*i] & w_gc[i]);
      w_gc[i+1]  = w_grp_g[i] | (w_grp_p[i] & w_gc[i]);
    end
  end

  assign w_sum  = w_p ^ w_c;
  assign w_cout = w_gc[8];

`ifdef CLA_ACC_SAT_EN
  // Once saturated, any further nonzero word carries out again, so the total stays pinned.
  assign w_acc_next = w_cout ? 32'hFFFF_FFFF : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  assign w_beat = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (start) begin
          w_next_state = (len == '0) ? c_done : c_accum;
        end
      end
      c_accum: begin
        if (w_beat && (r_remaining == {{(CNT_W-1){1'b0}}, 1'b1})) begin
          w_next_state = c_done;
        end
      end
      c_done: begin
        if (out_ready) begin
          w_next_state = c_idle;
        end
      end
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_accum);
    out_valid = (r_state == c_done);
    busy      = (r_state != c_idle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_remaining <= '0;
      r_carry_cnt <= '0;
    end else if ((r_state == c_idle) && start) begin
      r_acc       <= '0;
      r_carry_cnt <= '0;
      r_remaining <= len;
    end else if (w_beat) begin
      r_acc       <= w_acc_next;
      r_remaining <= r_remaining - {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_cout && !(&r_carry_cnt)) begin
        r_carry_cnt <= r_carry_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_sum   = r_acc;
  assign carry_cnt = r_carry_cnt;

endmodule
`default_nettype wire
